data_mem_responder: RTL and testbench

// - Memory-side responder for the GPU load/store units' valid/ready data-memory protocol.
// - Serves NUM_CHANNELS requesters (one per LSU) against an internal single-port RAM.
// - Round-robin arbitration, fixed access latency, 4-phase handshake.
// - Instantiated inside gpu_top beside the cores; the host load port preloads data before dispatch.

---
 rtl/data_mem_if.sv | 26 ++
 rtl/data_mem_responder.sv | 151 +++++++++++++++
 tb/tb_data_mem_responder.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// Valid/ready data-memory bus between the load/store units (master) and the responder (slave).
// Each field is packed per channel: channel i lives at [i*WIDTH +: WIDTH].
interface data_mem_if #(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned ADDR_BITS    = 8,
    parameter int unsigned DATA_BITS    = 8
);
    logic [NUM_CHANNELS-1:0]           read_valid;
    logic [NUM_CHANNELS*ADDR_BITS-1:0] read_address;
    logic [NUM_CHANNELS-1:0]           read_ready;
    logic [NUM_CHANNELS*DATA_BITS-1:0] read_data;
    logic [NUM_CHANNELS-1:0]           write_valid;
    logic [NUM_CHANNELS*ADDR_BITS-1:0] write_address;
    logic [NUM_CHANNELS*DATA_BITS-1:0] write_data;
    logic [NUM_CHANNELS-1:0]           write_ready;

    modport master (
        output read_valid, read_address, write_valid, write_address, write_data,
        input  read_ready, read_data, write_ready
    );

    modport slave (
        input  read_valid, read_address, write_valid, write_address, write_data,
        output read_ready, read_data, write_ready
    );
endinterface

// File: rtl/data_mem_responder.sv
// Round-robin, fixed-latency responder serving NUM_CHANNELS requesters from a single-port RAM.
// Optional MEM_STATS_EN adds saturating read/write transaction counters.
module data_mem_responder #(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned ADDR_BITS    = 8,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned LATENCY      = 2   // 1..15
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_if.slave            mem,
    input  logic                 host_we,
    input  logic [ADDR_BITS-1:0] host_addr,
    input  logic [DATA_BITS-1:0] host_wdata,
    output logic                 busy
`ifdef MEM_STATS_EN
    ,
    output logic [15:0]          read_count,
    output logic [15:0]          write_count
`endif
);

    localparam int unsigned ChW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StRespond} state_e;

    state_e                          state_q;
    logic [ChW-1:0]                  rr_q;
    logic [ChW-1:0]                  ch_q;
    logic                            op_wr_q;
    logic [ADDR_BITS-1:0]            addr_q;
    logic [DATA_BITS-1:0]            wdata_q;
    logic [3:0]                      cnt_q;
    logic [NUM_CHANNELS-1:0]         rd_rdy_q;
    logic [NUM_CHANNELS-1:0]         wr_rdy_q;
    logic [NUM_CHANNELS*DATA_BITS-1:0] rdata_q;
`ifdef MEM_STATS_EN
    logic [15:0]                     read_cnt_q;
    logic [15:0]                     write_cnt_q;
`endif

    logic [DATA_BITS-1:0] ram [2**ADDR_BITS];

    logic [NUM_CHANNELS-1:0] pending;
    logic                    grant_found_d;
    logic [ChW-1:0]          grant_ch_d;
    logic [ChW-1:0]          idx;
    logic                    busy_done;
    logic                    op_valid;
    logic                    commit_wr;

    // First pending channel at or after rr_q, wrapping around.
    always_comb begin
        pending       = mem.read_valid | mem.write_valid;
        grant_found_d = 1'b0;
        grant_ch_d    = rr_q;
        idx           = rr_q;
        for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
            idx = ChW'((32'(rr_q) + k) % NUM_CHANNELS);
            if (!grant_found_d && pending[idx]) begin
                grant_found_d = 1'b1;
                grant_ch_d    = idx;
            end
        end
    end

    always_comb begin
        busy_done = (state_q == StBusy) && (cnt_q == 4'(LATENCY - 1));
        op_valid  = op_wr_q ? mem.write_valid[ch_q] : mem.read_valid[ch_q];
        commit_wr = busy_done && op_wr_q && !reset;
    end

    // Host write is last so it wins a same-address collision with a channel commit.
    always_ff @(posedge clk) begin
        if (commit_wr) ram[addr_q] <= wdata_q;
        if (host_we)   ram[host_addr] <= host_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            rr_q     <= '0;
            ch_q     <= '0;
            op_wr_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rd_rdy_q <= '0;
            wr_rdy_q <= '0;
            rdata_q  <= '0;
`ifdef MEM_STATS_EN
            read_cnt_q  <= '0;
            write_cnt_q <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_found_d) begin
                        ch_q    <= grant_ch_d;
                        op_wr_q <= mem.write_valid[grant_ch_d];
                        addr_q  <= mem.write_valid[grant_ch_d]
                                   ? mem.write_address[grant_ch_d*ADDR_BITS +: ADDR_BITS]
                                   : mem.read_address[grant_ch_d*ADDR_BITS +: ADDR_BITS];
                        wdata_q <= mem.write_data[grant_ch_d*DATA_BITS +: DATA_BITS];
                        cnt_q   <= '0;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (busy_done) begin
                        state_q <= StRespond;
                        // Ready only if the requester is still waiting; an abandoned op just retires.
                        if (op_wr_q) begin
                            wr_rdy_q[ch_q] <= op_valid;
`ifdef MEM_STATS_EN
                            if (write_cnt_q != 16'hFFFF) write_cnt_q <= write_cnt_q + 16'd1;
`endif
                        end else begin
                            rd_rdy_q[ch_q] <= op_valid;
                            rdata_q[ch_q*DATA_BITS +: DATA_BITS] <= ram[addr_q];
`ifdef MEM_STATS_EN
                            if (read_cnt_q != 16'hFFFF) read_cnt_q <= read_cnt_q + 16'd1;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StRespond: begin
                    if (!op_valid) begin
                        rd_rdy_q <= '0;
                        wr_rdy_q <= '0;
                        rr_q     <= ChW'((32'(ch_q) + 32'd1) % NUM_CHANNELS);
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem.read_ready  = rd_rdy_q;
    assign mem.write_ready = wr_rdy_q;
    assign mem.read_data   = rdata_q;
    assign busy            = (state_q != StIdle);
`ifdef MEM_STATS_EN
    assign read_count  = read_cnt_q;
    assign write_count = write_cnt_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: a transaction-level model predicts every output each
// cycle, and directed scenarios pin the model with hand-computed expectations.
module tb_data_mem_responder;

    localparam int N   = 4;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          busy;
`ifdef MEM_STATS_EN
    logic [15:0]   read_count;
    logic [15:0]   write_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    data_mem_if #(.NUM_CHANNELS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) bus ();

    data_mem_responder #(
        .NUM_CHANNELS(N), .ADDR_BITS(AW), .DATA_BITS(DW), .LATENCY(LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem        (bus),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .busy       (busy)
`ifdef MEM_STATS_EN
        ,
        .read_count (read_count),
        .write_count(write_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    // ---------------- transaction-level reference model ----------------
    logic [DW-1:0]   m_mem [2**AW];
    bit              m_act = 1'b0;
    int              m_g, m_ch, m_rr = 0, m_cyc = 0;
    bit              m_wr;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_data;
    logic [N-1:0]    m_rrdy = '0, m_wrdy = '0;
    logic [N*DW-1:0] m_rdata = '0;
    int              m_rcnt = 0, m_wcnt = 0;

    // Grant at edge g; the memory effect lands at edge g+LAT; after that the transaction retires
    // at the first edge that sees the requester's valid low.
    task automatic model_step();
        bit v;
        int c;
        if (reset) begin
            m_act = 1'b0; m_rr = 0; m_rrdy = '0; m_wrdy = '0; m_rdata = '0;
            m_rcnt = 0; m_wcnt = 0;
        end else if (!m_act) begin
            for (int k = 0; k < N; k++) begin
                c = (m_rr + k) % N;
                if (!m_act && (bus.read_valid[c] || bus.write_valid[c])) begin
                    m_act  = 1'b1;
                    m_g    = m_cyc;
                    m_ch   = c;
                    m_wr   = bus.write_valid[c];
                    m_addr = m_wr ? bus.write_address[c*AW +: AW] : bus.read_address[c*AW +: AW];
                    m_data = bus.write_data[c*DW +: DW];
                end
            end
        end else begin
            v = m_wr ? bus.write_valid[m_ch] : bus.read_valid[m_ch];
            if (m_cyc == m_g + LAT) begin
                if (m_wr) begin
                    m_mem[m_addr] = m_data;
                    m_wrdy[m_ch]  = v;
                    if (m_wcnt < 65535) m_wcnt++;
                end else begin
                    m_rdata[m_ch*DW +: DW] = m_mem[m_addr];
                    m_rrdy[m_ch] = v;
                    if (m_rcnt < 65535) m_rcnt++;
                end
            end else if (m_cyc > m_g + LAT && !v) begin
                m_act = 1'b0; m_rrdy = '0; m_wrdy = '0; m_rr = (m_ch + 1) % N;
            end
        end
        if (host_we) m_mem[host_addr] = host_wdata;
        m_cyc++;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("busy", busy, m_act);
            check("read_ready", bus.read_ready, m_rrdy);
            check("write_ready", bus.write_ready, m_wrdy);
            check("read_data", bus.read_data, m_rdata);
`ifdef MEM_STATS_EN
            check("read_count", read_count, 16'(m_rcnt));
            check("write_count", write_count, 16'(m_wcnt));
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (busy == 1'b0) break;
            tick();
        end
        check("wait_idle", busy, 1'b0);
    endtask

    // Full 4-phase transaction from an idle FSM; lat = ticks until ready is seen.
    task automatic xact(input int c, input bit wr, input logic [7:0] a, input logic [7:0] d,
                        output int lat);
        lat = -1;
        if (wr) begin
            bus.write_valid[c] = 1'b1;
            bus.write_address[c*AW +: AW] = a;
            bus.write_data[c*DW +: DW] = d;
        end else begin
            bus.read_valid[c] = 1'b1;
            bus.read_address[c*AW +: AW] = a;
        end
        for (int i = 1; i <= 40; i++) begin
            tick();
            if ((wr ? bus.write_ready[c] : bus.read_ready[c]) == 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) check("xact_timeout", 64'(lat), 64'd3);
        if (wr) bus.write_valid[c] = 1'b0;
        else    bus.read_valid[c] = 1'b0;
        tick();
        wait_idle();
    endtask

    task automatic host_write(input logic [7:0] a, input logic [7:0] d);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        tick();
        host_we = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    int   lat;
    int   order[$];
    int   exp_ord[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] prev;
    bit   seen;
    int   n_resp;
    bit   any_prev, any_now;

    initial begin
        bus.read_valid = '0;  bus.read_address = '0;
        bus.write_valid = '0; bus.write_address = '0; bus.write_data = '0;
        host_we = 1'b0; host_addr = '0; host_wdata = '0;
        reset = 1'b1;
        tick(); tick();
        chk_en = 1'b1;
        check("reset_busy", busy, 1'b0);
        check("reset_read_ready", bus.read_ready, 4'h0);
        check("reset_write_ready", bus.write_ready, 4'h0);
        check("reset_read_data", bus.read_data, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 2**AW; i++) host_write(8'(i), 8'($urandom));

        // Preload then read: ready on the third edge after the request is first sampled.
        host_write(8'h10, 8'hA5);
        bus.read_valid[0] = 1'b1; bus.read_address[7:0] = 8'h10;
        tick(); tick();
        check("preload_early_ready", bus.read_ready[0], 1'b0);
        tick();
        check("preload_ready_t3", bus.read_ready[0], 1'b1);
        check("preload_data", bus.read_data[7:0], 8'hA5);
        bus.read_valid[0] = 1'b0;
        tick();
        wait_idle();

        // Write then read on channel 2.
        xact(2, 1'b1, 8'h20, 8'h3C, lat);
        check("wr_latency", 64'(lat), 64'd3);
        xact(2, 1'b0, 8'h20, 8'h00, lat);
        check("rd_latency", 64'(lat), 64'd3);
        check("wr_then_rd_data", bus.read_data[23:16], 8'h3C);

        // Fairness: all channels request from reset, re-requesting after each handshake.
        reset = 1'b1;
        for (int c = 0; c < N; c++) bus.read_address[c*AW +: AW] = 8'($urandom);
        bus.read_valid = '1;
        tick(); tick();
        reset = 1'b0;
        prev = '0;
        for (int i = 0; i < 200 && order.size() < 5; i++) begin
            tick();
            for (int c = 0; c < N; c++) begin
                if (bus.read_ready[c] && !prev[c]) begin
                    order.push_back(c);
                    bus.read_valid[c] = 1'b0;
                end else if (!bus.read_ready[c] && !bus.read_valid[c]) begin
                    bus.read_valid[c] = 1'b1;
                end
            end
            prev = bus.read_ready;
        end
        check("fair_count", 64'(order.size()), 64'd5);
        for (int i = 0; i < 5; i++)
            check("fair_order", (i < order.size()) ? 64'(order[i]) : 64'hFFFF, 64'(exp_ord[i]));
        bus.read_valid = '0;
        tick(); tick();
        wait_idle();

        // Abort: write valid dropped during BUSY still commits, but no ready pulse.
        bus.write_valid[1] = 1'b1; bus.write_address[15:8] = 8'h30; bus.write_data[15:8] = 8'h77;
        tick();
        check("abort_granted", busy, 1'b1);
        bus.write_valid[1] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen |= (bus.write_ready != '0);
        end
        check("abort_no_ready", seen, 1'b0);
        check("abort_idle", busy, 1'b0);
        xact(0, 1'b0, 8'h30, 8'h00, lat);
        check("abort_ram", bus.read_data[7:0], 8'h77);

        // Collision: host write lands on the commit edge and wins.
        bus.write_valid[0] = 1'b1; bus.write_address[7:0] = 8'h40; bus.write_data[7:0] = 8'h22;
        tick();
        for (int i = 0; i < LAT - 1; i++) tick();
        host_we = 1'b1; host_addr = 8'h40; host_wdata = 8'h11;
        tick();
        host_we = 1'b0;
        check("coll_wready", bus.write_ready[0], 1'b1);
        bus.write_valid[0] = 1'b0;
        tick();
        wait_idle();
        xact(0, 1'b0, 8'h40, 8'h00, lat);
        check("coll_host_wins", bus.read_data[7:0], 8'h11);

        // Reset in BUSY during a channel-3 write discards the write.
        host_write(8'h50, 8'h5A);
        bus.write_valid[3] = 1'b1; bus.write_address[31:24] = 8'h50; bus.write_data[31:24] = 8'h99;
        tick();
        check("rst_busy_granted", busy, 1'b1);
        reset = 1'b1; bus.write_valid[3] = 1'b0;
        tick();
        reset = 1'b0;
        check("rst_busy_rready", bus.read_ready, 4'h0);
        check("rst_busy_wready", bus.write_ready, 4'h0);
        check("rst_busy_idle", busy, 1'b0);
`ifdef MEM_STATS_EN
        check("rst_read_count", read_count, 16'h0);
        check("rst_write_count", write_count, 16'h0);
`endif
        xact(3, 1'b0, 8'h50, 8'h00, lat);
        check("rst_write_dropped", bus.read_data[31:24], 8'h5A);

        // Randomized traffic on a small address window, with aborts, address churn,
        // host writes and occasional resets.
        n_resp = 0;
        any_prev = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            any_now = (bus.read_ready != '0) || (bus.write_ready != '0);
            if (any_now && !any_prev) n_resp++;
            any_prev = any_now;
            reset      = ($urandom_range(0, 399) == 0);
            host_we    = ($urandom_range(0, 7) == 0);
            host_addr  = 8'($urandom_range(0, 15));
            host_wdata = 8'($urandom);
            for (int c = 0; c < N; c++) begin
                if (bus.read_valid[c]) begin
                    if (bus.read_ready[c] || $urandom_range(0, 39) == 0) bus.read_valid[c] = 1'b0;
                    else if ($urandom_range(0, 19) == 0)
                        bus.read_address[c*AW +: AW] = 8'($urandom_range(0, 15));
                end else if (!bus.read_ready[c] && $urandom_range(0, 3) == 0) begin
                    bus.read_valid[c] = 1'b1;
                    bus.read_address[c*AW +: AW] = 8'($urandom_range(0, 15));
                end
                if (bus.write_valid[c]) begin
                    if (bus.write_ready[c] || $urandom_range(0, 39) == 0) bus.write_valid[c] = 1'b0;
                    else if ($urandom_range(0, 19) == 0)
                        bus.write_data[c*DW +: DW] = 8'($urandom);
                end else if (!bus.write_ready[c] && $urandom_range(0, 5) == 0) begin
                    bus.write_valid[c] = 1'b1;
                    bus.write_address[c*AW +: AW] = 8'($urandom_range(0, 15));
                    bus.write_data[c*DW +: DW] = 8'($urandom);
                end
            end
        end
        reset = 1'b0; host_we = 1'b0;
        bus.read_valid = '0; bus.write_valid = '0;
        tick(); tick();
        wait_idle();
        check("rand_progress", 64'(n_resp > 50), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
